// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file.
// Default widths and register count live here.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 6;
    localparam int NREGS_DEF  = 32;

    typedef logic [DATA_W_DEF-1:0] word_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: decode, zero/range masking, write bypass.
// Bypass mux is present only when REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic [DATA_W-1:0] regs_i [NREGS],
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              byp_en_i,
    input  logic [ADDR_W-1:0] byp_addr_i,
    input  logic [DATA_W-1:0] byp_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] rd_data_d;

    // Unknown or out-of-range addresses never match and fall through to zero.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (i != 0 && rd_addr_i == i[ADDR_W-1:0]) begin
                rd_data_d = regs_i[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rd_data_o = rd_data_d;
        if (byp_en_i && rd_addr_i == byp_addr_i) begin
            rd_data_o = byp_data_i;
        end
    end
`else
    logic unused_byp;
    assign unused_byp = ^{byp_en_i, byp_addr_i, byp_data_i};
    assign rd_data_o  = rd_data_d;
`endif

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with hardwired-zero register 0.
// Optional write-to-read forwarding via REGFILE_BYPASS_EN.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] Read1,
    input  logic [ADDR_W-1:0] Read2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] Data1,
    output logic [DATA_W-1:0] Data2
);

    localparam logic [ADDR_W:0] NREGS_W = (ADDR_W+1)'(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              wr_ok;
    logic              byp_en;

    assign wr_ok = RegWrite && (WriteReg != '0)
                && ({1'b0, WriteReg} < NREGS_W);

    // Forwarding is gated by reset so reads stay zero while it is held.
    assign byp_en = reset_n && wr_ok;

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREGS; i++) begin
            if (wr_ok && WriteReg == i[ADDR_W-1:0]) begin
                regs_d[i] = WriteData;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_rd1 (
        .regs_i     (regs_q),
        .rd_addr_i  (Read1),
        .byp_en_i   (byp_en),
        .byp_addr_i (WriteReg),
        .byp_data_i (WriteData),
        .rd_data_o  (Data1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_rd2 (
        .regs_i     (regs_q),
        .rd_addr_i  (Read2),
        .byp_en_i   (byp_en),
        .byp_addr_i (WriteReg),
        .byp_data_i (WriteData),
        .rd_data_o  (Data2)
    );

endmodule

// File: tb/tb_register_file.sv
// Randomized bench for register_file with a behavioural array model.
// Honours REGFILE_BYPASS_EN when defined for the build.
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 32;

    logic          clock;
    logic          reset_n;
    logic [AW-1:0] Read1;
    logic [AW-1:0] Read2;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic          RegWrite;
    logic [DW-1:0] Data1;
    logic [DW-1:0] Data2;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    logic [DW-1:0] model [NR];

    register_file #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .Read1     (Read1),
        .Read2     (Read2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .Data1     (Data1),
        .Data2     (Data2)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit wr_legal();
        return RegWrite && int'(WriteReg) != 0 && int'(WriteReg) < NR;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (!reset_n) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_legal() && a == WriteReg) return WriteData;
`endif
        if (int'(a) != 0 && int'(a) < NR) return model[int'(a)];
        return '0;
    endfunction

    initial for (int i = 0; i < NR; i++) model[i] = '0;

    always @(negedge reset_n)
        for (int i = 0; i < NR; i++) model[i] = '0;

    always @(posedge clock)
        if (reset_n && wr_legal()) model[int'(WriteReg)] = WriteData;

    always @(negedge clock)
        if (chk_en) begin
            chk("rand_d1", Data1, exp_rd(Read1));
            chk("rand_d2", Data2, exp_rd(Read2));
        end

    task automatic wr(input int a, input logic [DW-1:0] d);
        @(negedge clock);
        RegWrite  = 1;
        WriteReg  = AW'(a);
        WriteData = d;
        @(posedge clock);
        #1;
        RegWrite = 0;
    endtask

    initial begin
        reset_n = 0; RegWrite = 0; WriteReg = 0; WriteData = 0;
        Read1 = 7; Read2 = 10;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1;
        #1;
        chk("reset_d1", Data1, 32'h0);
        chk("reset_d2", Data2, 32'h0);

        wr(3, 32'hABCDEFFF);
        wr(5, 32'hFBCDE111);
        Read1 = 3; Read2 = 5; #1;
        chk("wr3_d1", Data1, 32'hABCDEFFF);
        chk("wr5_d2", Data2, 32'hFBCDE111);

        Read1 = 5; #1;
        chk("same_addr", Data1, Data2);

        wr(0, 32'h12345678);
        Read1 = 0; #1;
        chk("reg0_zero", Data1, 32'h0);

        @(negedge clock);
        RegWrite = 0; WriteReg = 3; WriteData = 32'h11111111;
        @(posedge clock); #1;
        Read1 = 3; #1;
        chk("we_low_hold", Data1, 32'hABCDEFFF);

        wr(40, 32'hDEADBEEF);
        Read1 = 40; Read2 = 8; #1;
        chk("oor_read", Data1, 32'h0);
        chk("oor_no_alias", Data2, 32'h0);

        wr(31, 32'h5A5A5A5A);
        Read1 = 31; #1;
        chk("top_reg", Data1, 32'h5A5A5A5A);

        Read1 = 'x; @(posedge clock); #1;
        Read1 = 3; #1;
        chk("x_addr_safe", Data1, 32'hABCDEFFF);

        @(negedge clock);
        RegWrite = 1; WriteReg = 9; Read1 = 9; WriteData = 32'hCAFEF00D;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_pre", Data1, 32'hCAFEF00D);
`else
        chk("nobyp_pre", Data1, 32'h0);
`endif
        @(posedge clock); #1;
        chk("post_edge", Data1, 32'hCAFEF00D);
        RegWrite = 0;

        Read1 = 3; Read2 = 5;
        @(posedge clock); #2;
        RegWrite = 1; WriteReg = 9; WriteData = 32'h77777777;
        reset_n = 0; #1;
        chk("async_rst_d1", Data1, 32'h0);
        chk("async_rst_d2", Data2, 32'h0);
        Read1 = 9; #1;
        chk("rst_no_byp", Data1, 32'h0);
        @(posedge clock);
        @(negedge clock);
        RegWrite = 0; reset_n = 1; #1;
        chk("rst_no_write", Data1, 32'h0);

        @(posedge clock); #1;
        chk_en = 1;
        for (int n = 0; n < 400; n++) begin
            RegWrite  = ($urandom_range(0, 3) != 0);
            WriteReg  = AW'($urandom_range(0, 40));
            WriteData = $urandom;
            Read1 = ($urandom_range(0, 3) == 0) ? WriteReg
                                                : AW'($urandom_range(0, 63));
            Read2 = ($urandom_range(0, 3) == 0) ? WriteReg
                                                : AW'($urandom_range(0, 63));
            if ($urandom_range(0, 99) == 0) begin
                #2 reset_n = 0;
                @(posedge clock); #1;
                reset_n = 1;
            end else begin
                @(posedge clock); #1;
            end
        end
        chk_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
